warp_wb_arbiter: RTL and testbench

Writeback arbiter that shares the two register-file write ports (rd1/rd2) among NUM_REQ execution-unit result streams, such as xarith, xlogic and future shift/mem units.
- Gives each requester a one-entry result slot and real ready/valid backpressure.
- Grants up to two slots per cycle in round-robin order.
- Produces the per-port retire masks consumed by the issue scoreboard.
- Sits between the execution units and warp_xrf.

---
 rtl/warp_wb_arbiter_pkg.sv | 22 ++
 rtl/warp_rr_pick2.sv | 57 +++++
 rtl/warp_wb_arbiter.sv | 108 ++++++++++
 tb/tb_warp_wb_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/warp_wb_arbiter_pkg.sv
// Shared constants and helpers for the writeback arbiter and its round-robin picker.
package warp_wb_arbiter_pkg;

    localparam int WB_NUM_REQ = 4;
    localparam int WB_XLEN    = 64;
    localparam int WB_RD_W    = 5;

    // Requester slot assignment for the execution units feeding writeback.
    localparam int WB_REQ_XARITH = 0;
    localparam int WB_REQ_XLOGIC = 1;
    localparam int WB_REQ_XSHIFT = 2;
    localparam int WB_REQ_XMEM   = 3;

    function automatic int wb_wrap(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction

    function automatic logic [31:0] wb_retire_mask(input logic wen, input logic [WB_RD_W-1:0] rd);
        return wen ? (32'h1 << rd) : 32'h0;
    endfunction

endpackage

// File: rtl/warp_rr_pick2.sv
// Combinational round-robin picker: up to two non-zero, distinct-rd grants per cycle;
// rd==0 entries are drained without consuming a port.
module warp_rr_pick2
    import warp_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = WB_NUM_REQ,
    parameter int PTR_W   = $clog2(WB_NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]         i_valid,
    input  logic [WB_RD_W*NUM_REQ-1:0] i_rd,
    input  logic [PTR_W-1:0]           i_ptr,
    output logic [NUM_REQ-1:0]         o_grant1,
    output logic [NUM_REQ-1:0]         o_grant2,
    output logic [NUM_REQ-1:0]         o_drain,
    output logic [PTR_W-1:0]           o_next_ptr
);

    // NOTE: every variable assigned in this block gets a default first, so no latch is inferred.
    always_comb begin
        int                 w_idx;
        logic               w_have1;
        logic               w_have2;
        logic [WB_RD_W-1:0] w_rd;
        logic [WB_RD_W-1:0] w_rd1;

        o_grant1   = '0;
        o_grant2   = '0;
        o_drain    = '0;
        o_next_ptr = i_ptr;
        w_have1    = 1'b0;
        w_have2    = 1'b0;
        w_rd1      = '0;
        w_idx      = 0;
        w_rd       = '0;

        for (int off = 0; off < NUM_REQ; off++) begin
            w_idx = wb_wrap(int'(i_ptr) + off, NUM_REQ);
            w_rd  = i_rd[WB_RD_W*w_idx +: WB_RD_W];
            if (i_valid[w_idx]) begin
                if (w_rd == '0) begin
                    o_drain[w_idx] = 1'b1;
                end else if (!w_have1) begin
                    w_have1         = 1'b1;
                    w_rd1           = w_rd;
                    o_grant1[w_idx] = 1'b1;
                    o_next_ptr      = PTR_W'(wb_wrap(w_idx + 1, NUM_REQ));
                end else if (!w_have2 && (w_rd != w_rd1)) begin
                    // A same-rd follower is skipped so two writes never collide on one register.
                    w_have2         = 1'b1;
                    o_grant2[w_idx] = 1'b1;
                    o_next_ptr      = PTR_W'(wb_wrap(w_idx + 1, NUM_REQ));
                end
            end
        end
    end

endmodule

// File: rtl/warp_wb_arbiter.sv
// Writeback arbiter: one result slot per execution unit, sharing the two register-file
// write ports in round-robin order and producing the scoreboard retire masks.
module warp_wb_arbiter
    import warp_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = WB_NUM_REQ,
    parameter int XLEN    = WB_XLEN
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [NUM_REQ-1:0]         i_req_valid,
    output logic [NUM_REQ-1:0]         o_req_ready,
    input  logic [WB_RD_W*NUM_REQ-1:0] i_req_rd,
    input  logic [XLEN*NUM_REQ-1:0]    i_req_wdata,
    output logic                       o_rd1_wen,
    output logic [WB_RD_W-1:0]         o_rd1_addr,
    output logic [XLEN-1:0]            o_rd1_wdata,
    output logic                       o_rd2_wen,
    output logic [WB_RD_W-1:0]         o_rd2_addr,
    output logic [XLEN-1:0]            o_rd2_wdata,
    output logic [31:0]                o_retire0,
    output logic [31:0]                o_retire1
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]         r_valid;
    logic [WB_RD_W-1:0]         r_rd   [NUM_REQ];
    logic [XLEN-1:0]            r_data [NUM_REQ];
    logic [PTR_W-1:0]           r_ptr;

    logic [WB_RD_W*NUM_REQ-1:0] w_rd_vec;
    logic [NUM_REQ-1:0]         w_grant1;
    logic [NUM_REQ-1:0]         w_grant2;
    logic [NUM_REQ-1:0]         w_drain;
    logic [NUM_REQ-1:0]         w_grant;
    logic [NUM_REQ-1:0]         w_ready;
    logic [PTR_W-1:0]           w_next_ptr;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_rd_vec
        assign w_rd_vec[WB_RD_W*g +: WB_RD_W] = r_rd[g];
    end

    warp_rr_pick2 #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .i_valid    (r_valid),
        .i_rd       (w_rd_vec),
        .i_ptr      (r_ptr),
        .o_grant1   (w_grant1),
        .o_grant2   (w_grant2),
        .o_drain    (w_drain),
        .o_next_ptr (w_next_ptr)
    );

    // A slot being emptied this cycle can be refilled in the same cycle.
    assign w_grant     = w_grant1 | w_grant2 | w_drain;
    assign w_ready     = ~r_valid | w_grant;
    assign o_req_ready = w_ready;

    assign o_rd1_wen = |w_grant1;
    assign o_rd2_wen = |w_grant2;

    always_comb begin
        o_rd1_addr  = '0;
        o_rd1_wdata = '0;
        o_rd2_addr  = '0;
        o_rd2_wdata = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_grant1[k]) begin
                o_rd1_addr  = r_rd[k];
                o_rd1_wdata = r_data[k];
            end
            if (w_grant2[k]) begin
                o_rd2_addr  = r_rd[k];
                o_rd2_wdata = r_data[k];
            end
        end
    end

    assign o_retire0 = wb_retire_mask(o_rd1_wen, o_rd1_addr);
    assign o_retire1 = wb_retire_mask(o_rd2_wen, o_rd2_addr);

    // NOTE: slot rd/data are reset too, so the write-port buses are never X while idle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= '0;
            r_ptr   <= '0;
            for (int k = 0; k < NUM_REQ; k++) begin
                r_rd[k]   <= '0;
                r_data[k] <= '0;
            end
        end else begin
            r_ptr <= w_next_ptr;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (i_req_valid[k] && w_ready[k]) begin
                    r_valid[k] <= 1'b1;
                    r_rd[k]    <= i_req_rd[WB_RD_W*k +: WB_RD_W];
                    r_data[k]  <= i_req_wdata[XLEN*k +: XLEN];
                end else if (w_grant[k]) begin
                    r_valid[k] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_warp_wb_arbiter.sv
// Self-checking bench for warp_wb_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a behavioural slot/round-robin model.
module tb_warp_wb_arbiter;

    localparam int N    = 4;
    localparam int XLEN = 64;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [5*N-1:0]    req_rd;
    logic [XLEN*N-1:0] req_wdata;
    logic              rd1_wen, rd2_wen;
    logic [4:0]        rd1_addr, rd2_addr;
    logic [XLEN-1:0]   rd1_wdata, rd2_wdata;
    logic [31:0]       retire0, retire1;

    warp_wb_arbiter #(.NUM_REQ(N), .XLEN(XLEN)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_rd    (req_rd),
        .i_req_wdata (req_wdata),
        .o_rd1_wen   (rd1_wen),
        .o_rd1_addr  (rd1_addr),
        .o_rd1_wdata (rd1_wdata),
        .o_rd2_wen   (rd2_wen),
        .o_rd2_addr  (rd2_addr),
        .o_rd2_wdata (rd2_wdata),
        .o_retire0   (retire0),
        .o_retire1   (retire1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model of the arbiter: contents of each one-entry slot plus the round-robin start index.
    logic         m_valid [N];
    logic [4:0]   m_rd    [N];
    logic [63:0]  m_data  [N];
    int           m_ptr;

    int acc_nz      = 0;  // accepted results with a non-zero destination
    int discard_nz  = 0;  // non-zero results thrown away by reset
    int obs_writes  = 0;  // write-port enables seen on the DUT

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Walk requesters in round-robin order from the pointer: zero destinations drain,
    // the first non-zero takes port 1, the next non-zero with a different rd takes port 2.
    function automatic void model_pick(output int p1, output int p2, output logic [N-1:0] drn);
        int order[$];
        p1  = -1;
        p2  = -1;
        drn = '0;
        for (int i = 0; i < N; i++) order.push_back((m_ptr + i) % N);
        foreach (order[j]) begin
            int k;
            k = order[j];
            if (m_valid[k]) begin
                if (m_rd[k] == 5'd0) drn[k] = 1'b1;
                else if (p1 < 0) p1 = k;
                else if (p2 < 0 && m_rd[k] != m_rd[p1]) p2 = k;
            end
        end
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < N; k++) begin
            if (m_valid[k] && m_rd[k] != 5'd0) discard_nz++;
            m_valid[k] = 1'b0;
            m_rd[k]    = '0;
            m_data[k]  = '0;
        end
        m_ptr = 0;
    endfunction

    // One cycle, entered at a falling edge: compare outputs, drive inputs, advance model.
    task automatic step(input logic [N-1:0] v, input logic [5*N-1:0] rd, input logic [XLEN*N-1:0] wd);
        int           p1, p2;
        logic [N-1:0] drn, g, exp_ready;
        model_pick(p1, p2, drn);
        g = drn;
        if (p1 >= 0) g[p1] = 1'b1;
        if (p2 >= 0) g[p2] = 1'b1;
        exp_ready = '0;
        for (int k = 0; k < N; k++) exp_ready[k] = !m_valid[k] || g[k];

        check("ready", 64'(req_ready), 64'(exp_ready));
        check("rd1_wen", 64'(rd1_wen), 64'(p1 >= 0));
        check("rd2_wen", 64'(rd2_wen), 64'(p2 >= 0));
        if (p1 >= 0) begin
            check("rd1_addr", 64'(rd1_addr), 64'(m_rd[p1]));
            check("rd1_wdata", rd1_wdata, m_data[p1]);
            check("retire0", 64'(retire0), 64'(32'h1 << m_rd[p1]));
        end else begin
            check("retire0_idle", 64'(retire0), 64'd0);
        end
        if (p2 >= 0) begin
            check("rd2_addr", 64'(rd2_addr), 64'(m_rd[p2]));
            check("rd2_wdata", rd2_wdata, m_data[p2]);
            check("retire1", 64'(retire1), 64'(32'h1 << m_rd[p2]));
        end else begin
            check("retire1_idle", 64'(retire1), 64'd0);
        end
        obs_writes += int'(rd1_wen) + int'(rd2_wen);

        req_valid = v;
        req_rd    = rd;
        req_wdata = wd;

        for (int k = 0; k < N; k++) begin
            if (v[k] && exp_ready[k]) begin
                m_valid[k] = 1'b1;
                m_rd[k]    = rd[5*k +: 5];
                m_data[k]  = wd[XLEN*k +: XLEN];
                if (rd[5*k +: 5] != 5'd0) acc_nz++;
            end else if (g[k]) begin
                m_valid[k] = 1'b0;
            end
        end
        if (p2 >= 0) m_ptr = (p2 + 1) % N;
        else if (p1 >= 0) m_ptr = (p1 + 1) % N;

        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step('0, '0, '0);
    endtask

    // Asynchronous reset asserted between clock edges; outputs must clear at once.
    task automatic async_reset(input string tag);
        #2;
        rst_n     = 1'b0;
        req_valid = '0;
        #1;
        check({tag, "_wen1"}, 64'(rd1_wen), 64'd0);
        check({tag, "_wen2"}, 64'(rd2_wen), 64'd0);
        check({tag, "_ret0"}, 64'(retire0), 64'd0);
        check({tag, "_ret1"}, 64'(retire1), 64'd0);
        check({tag, "_ready"}, 64'(req_ready), 64'hF);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [N-1:0]      v;
    logic [5*N-1:0]    rd;
    logic [XLEN*N-1:0] wd;
    int                cyc;

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_rd    = '0;
        req_wdata = '0;
        for (int k = 0; k < N; k++) begin
            m_valid[k] = 1'b0;
            m_rd[k]    = '0;
            m_data[k]  = '0;
        end
        m_ptr = 0;
        #1;
        check("por_ready", 64'(req_ready), 64'hF);
        check("por_wen1", 64'(rd1_wen), 64'd0);
        check("por_ret0", 64'(retire0), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // Mid-traffic reset: fill all slots, reset before they drain, expect no stale writes.
        rd = {5'd4, 5'd3, 5'd2, 5'd1};
        wd = {64'h44, 64'h33, 64'h22, 64'h11};
        step(4'hF, rd, wd);
        async_reset("rst_mid");
        idle(1);
        check("rst_no_stale", 64'(rd1_wen | rd2_wen), 64'd0);
        idle(1);

        // Two requesters granted together.
        rd = '0; wd = '0;
        rd[4:0] = 5'd5;  wd[63:0]   = 64'hAA;
        rd[9:5] = 5'd6;  wd[127:64] = 64'hBB;
        step(4'b0011, rd, wd);
        check("two_addr1", 64'(rd1_addr), 64'd5);
        check("two_data1", rd1_wdata, 64'hAA);
        check("two_addr2", 64'(rd2_addr), 64'd6);
        check("two_data2", rd2_wdata, 64'hBB);
        check("two_ret0", 64'(retire0), 64'h20);
        check("two_ret1", 64'(retire1), 64'h40);
        // Pointer now 2: with req0 and req2 both waiting, req2 must win port 1.
        rd = '0; wd = '0;
        rd[4:0]   = 5'd10; wd[63:0]    = 64'h1010;
        rd[14:10] = 5'd12; wd[191:128] = 64'h1212;
        step(4'b0000, '0, '0);
        step(4'b0101, rd, wd);
        check("ptr2_addr1", 64'(rd1_addr), 64'd12);
        check("ptr2_addr2", 64'(rd2_addr), 64'd10);
        idle(1);

        // Oversubscription from a fresh pointer: pairs alternate, ready toggles.
        async_reset("rst_over");
        rd = {5'd4, 5'd3, 5'd2, 5'd1};
        wd = {64'h4, 64'h3, 64'h2, 64'h1};
        step(4'hF, rd, wd);
        check("over_c1_ready", 64'(req_ready), 64'b0011);
        check("over_c1_addr1", 64'(rd1_addr), 64'd1);
        check("over_c1_addr2", 64'(rd2_addr), 64'd2);
        step(4'hF, rd, wd);
        check("over_c2_ready", 64'(req_ready), 64'b1100);
        check("over_c2_addr1", 64'(rd1_addr), 64'd3);
        check("over_c2_addr2", 64'(rd2_addr), 64'd4);
        for (int i = 0; i < 4; i++) step(4'hF, rd, wd);
        idle(3);

        // x0 drain alongside a real write.
        async_reset("rst_drain");
        rd = '0; wd = '0;
        rd[4:0] = 5'd7; wd[63:0] = 64'h77;
        rd[14:10] = 5'd0; wd[191:128] = 64'h99;
        step(4'b0101, rd, wd);
        check("drain_addr1", 64'(rd1_addr), 64'd7);
        check("drain_wen2", 64'(rd2_wen), 64'd0);
        check("drain_ret1", 64'(retire1), 64'd0);
        check("drain_ready2", 64'(req_ready[2]), 64'd1);
        idle(1);
        check("drain_cleared", 64'(rd1_wen), 64'd0);

        // Same destination on two slots: serialised over two cycles.
        async_reset("rst_same");
        rd = '0; wd = '0;
        rd[4:0] = 5'd9; wd[63:0]   = 64'h901;
        rd[9:5] = 5'd9; wd[127:64] = 64'h902;
        step(4'b0011, rd, wd);
        check("same_data1", rd1_wdata, 64'h901);
        check("same_wen2", 64'(rd2_wen), 64'd0);
        step('0, '0, '0);
        check("same_next_data1", rd1_wdata, 64'h902);
        idle(1);

        // Backpressure: req3 waits one cycle while its input data changes.
        async_reset("rst_hold");
        rd = {5'd3, 5'd0, 5'd2, 5'd1};
        wd = {64'h333, 64'h0, 64'h222, 64'h111};
        step(4'b1011, rd, wd);
        check("hold_ready3", 64'(req_ready[3]), 64'd0);
        wd[255:192] = 64'hDEAD;
        step(4'b1000, rd, wd);
        check("hold_addr1", 64'(rd1_addr), 64'd3);
        check("hold_data1", rd1_wdata, 64'h333);
        step('0, '0, '0);
        idle(2);

        // Randomized traffic with a reset in the middle; count writes end to end.
        acc_nz     = 0;
        discard_nz = 0;
        obs_writes = 0;
        cyc        = 0;
        while (acc_nz < 1000 && cyc < 20000) begin
            for (int k = 0; k < N; k++) begin
                v[k]            = ($urandom_range(0, 9) < 6);
                rd[5*k +: 5]    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                wd[XLEN*k +: XLEN] = {$urandom, $urandom};
            end
            if (cyc == 300) async_reset("rst_rand");
            else step(v, rd, wd);
            cyc++;
        end
        check("rand_budget", 64'(acc_nz >= 1000), 64'd1);
        idle(2 * N);
        check("write_count", 64'(obs_writes), 64'(acc_nz - discard_nz));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
